// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
//   hz_tag_t    : shadow tag carried through EX, MEM and WB
//   hz_action_e : per-cycle pipeline action, highest priority last in list
//   FWD_*       : EX operand forward-select encodings
package pipeline_pkg;

    // Tag address fields are sized for the widest supported register file;
    // narrower register addresses are zero-extended into them.
    localparam int HZ_ADDR_W = 8;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        STALL  = 2'b01,
        FLUSH  = 2'b10,
        FREEZE = 2'b11
    } hz_action_e;

    typedef struct packed {
        logic                 valid;
        logic [HZ_ADDR_W-1:0] rs;
        logic [HZ_ADDR_W-1:0] rt;
        logic [HZ_ADDR_W-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } hz_tag_t;

    // True when a tag will write a real (non-zero) register.
    function automatic logic tag_writes_reg(input hz_tag_t t);
        return t.valid && t.regwrite && (t.rd != {HZ_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forward selector for one EX source operand.
//   src     : source register of the instruction in EX
//   mem_tag : tag of the instruction in MEM (EX/MEM register)
//   wb_tag  : tag of the instruction in WB (MEM/WB register)
//   sel     : FWD_EXMEM, FWD_MEMWB or FWD_REG
module fwd_select
    import pipeline_pkg::*;
(
    input  logic [HZ_ADDR_W-1:0] src,
    input  hz_tag_t              mem_tag,
    input  hz_tag_t              wb_tag,
    output logic [1:0]           sel
);

    // Source fields of the older tags play no part in forwarding.
    logic unused_fields_s;
    assign unused_fields_s = ^{mem_tag.rs, mem_tag.rt, wb_tag.rs, wb_tag.rt, wb_tag.memread};

    // Youngest producer wins; a load still in MEM has no data yet, so it is skipped.
    always_comb begin
        if (tag_writes_reg(mem_tag) && !mem_tag.memread && (mem_tag.rd == src)) begin
            sel = FWD_EXMEM;
        end else if (tag_writes_reg(wb_tag) && (wb_tag.rd == src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_REG;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline.
// Keeps shadow tags for EX/MEM/WB and derives freeze, flush, load-use stall
// and forward selects from them; counts each event in saturating counters.
//   clk, rst                 : clock, synchronous active-high reset
//   id_*                     : fields of the instruction in IF/ID
//   ex_branch_taken          : branch resolved taken in EX
//   mem_busy                 : data memory not ready, freeze everything
//   pc_hold, ifid_hold       : hold PC and IF/ID
//   ifid_flush, idex_bubble  : clear IF/ID, zero ID/EX control
//   pipe_freeze              : hold all pipeline registers
//   fwd_a_sel, fwd_b_sel     : EX operand forward selects
//   stall_cnt/flush_cnt/freeze_cnt : saturating event counters
// REG_ADDR_W must not exceed pipeline_pkg::HZ_ADDR_W.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  pc_hold,
    output logic                  ifid_hold,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  pipe_freeze,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      freeze_cnt
);

    hz_tag_t                ex_tag_r, mem_tag_r, wb_tag_r;
    hz_tag_t                id_tag_s;
    hz_action_e             action_s;
    logic                   load_use_s;
    logic [1:0]             fwd_a_s, fwd_b_s;
    logic [CNT_W-1:0]       stall_cnt_r, flush_cnt_r, freeze_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // A loading tag blocks ID when ID reads the register the load writes.
    function automatic logic load_hit(input hz_tag_t t, input hz_tag_t id);
        return t.valid && t.memread && (t.rd != {HZ_ADDR_W{1'b0}}) &&
               ((id_uses_rs && (id.rs == t.rd)) || (id_uses_rt && (id.rt == t.rd)));
    endfunction

    // Zero-extend the ID fields into tag form.
    always_comb begin
        id_tag_s          = '0;
        id_tag_s.valid    = id_valid;
        id_tag_s.rs[REG_ADDR_W-1:0] = id_rs;
        id_tag_s.rt[REG_ADDR_W-1:0] = id_rt;
        id_tag_s.rd[REG_ADDR_W-1:0] = id_rd;
        id_tag_s.regwrite = id_regwrite;
        id_tag_s.memread  = id_memread;
    end

    // Action priority: reset, freeze, flush, load-use stall, run.
    always_comb begin
        load_use_s = id_valid && (load_hit(ex_tag_r, id_tag_s) ||
                     ((LOAD_USE_STALLS == 2) && load_hit(mem_tag_r, id_tag_s)));
        if (rst) begin
            action_s = RUN;
        end else if (mem_busy) begin
            action_s = FREEZE;
        end else if (ex_branch_taken) begin
            action_s = FLUSH;
        end else if (load_use_s) begin
            action_s = STALL;
        end else begin
            action_s = RUN;
        end
    end

    // Pipeline control outputs decoded from the current action.
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        case (action_s)
            FREEZE: begin
                pipe_freeze = 1'b1;
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
            end
            FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            STALL: begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
            end
            RUN: begin
                pc_hold     = 1'b0;
            end
            default: begin
                pc_hold     = 1'b0;
            end
        endcase
    end

    fwd_select u_fwd_a (
        .src     (ex_tag_r.rs),
        .mem_tag (mem_tag_r),
        .wb_tag  (wb_tag_r),
        .sel     (fwd_a_s)
    );

    fwd_select u_fwd_b (
        .src     (ex_tag_r.rt),
        .mem_tag (mem_tag_r),
        .wb_tag  (wb_tag_r),
        .sel     (fwd_b_s)
    );

    // Forward selects are forced to the register file while in reset.
    always_comb begin
        if (rst) begin
            fwd_a_sel = FWD_REG;
            fwd_b_sel = FWD_REG;
        end else begin
            fwd_a_sel = fwd_a_s;
            fwd_b_sel = fwd_b_s;
        end
    end

    // Shadow tag pipeline: hold on freeze, inject a bubble on flush/stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_tag_r  <= '0;
            mem_tag_r <= '0;
            wb_tag_r  <= '0;
        end else begin
            case (action_s)
                FREEZE: begin
                    ex_tag_r  <= ex_tag_r;
                    mem_tag_r <= mem_tag_r;
                    wb_tag_r  <= wb_tag_r;
                end
                FLUSH, STALL: begin
                    ex_tag_r  <= '0;
                    mem_tag_r <= ex_tag_r;
                    wb_tag_r  <= mem_tag_r;
                end
                RUN: begin
                    ex_tag_r  <= id_tag_s;
                    mem_tag_r <= ex_tag_r;
                    wb_tag_r  <= mem_tag_r;
                end
                default: begin
                    ex_tag_r  <= ex_tag_r;
                    mem_tag_r <= mem_tag_r;
                    wb_tag_r  <= wb_tag_r;
                end
            endcase
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r  <= '0;
            flush_cnt_r  <= '0;
            freeze_cnt_r <= '0;
        end else begin
            case (action_s)
                FREEZE:  freeze_cnt_r <= sat_inc(freeze_cnt_r);
                FLUSH:   flush_cnt_r  <= sat_inc(flush_cnt_r);
                STALL:   stall_cnt_r  <= sat_inc(stall_cnt_r);
                default: stall_cnt_r  <= stall_cnt_r;
            endcase
        end
    end

    assign stall_cnt  = stall_cnt_r;
    assign flush_cnt  = flush_cnt_r;
    assign freeze_cnt = freeze_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
    logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0;
    logic       br = 1'b0, busy = 1'b0;

    logic        d1_pc_hold, d1_ifid_hold, d1_ifid_flush, d1_idex_bubble, d1_pipe_freeze;
    logic [1:0]  d1_fwd_a, d1_fwd_b;
    logic [15:0] d1_stall_cnt, d1_flush_cnt, d1_freeze_cnt;
    logic        d2_pc_hold, d2_ifid_hold, d2_ifid_flush, d2_idex_bubble, d2_pipe_freeze;
    logic [1:0]  d2_fwd_a, d2_fwd_b;
    logic [15:0] d2_stall_cnt, d2_flush_cnt, d2_freeze_cnt;
    logic        d3_pc_hold, d3_ifid_hold, d3_ifid_flush, d3_idex_bubble, d3_pipe_freeze;
    logic [1:0]  d3_fwd_a, d3_fwd_b;
    logic [3:0]  d3_stall_cnt, d3_flush_cnt, d3_freeze_cnt;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .ex_branch_taken(br), .mem_busy(busy),
        .pc_hold(d1_pc_hold), .ifid_hold(d1_ifid_hold), .ifid_flush(d1_ifid_flush),
        .idex_bubble(d1_idex_bubble), .pipe_freeze(d1_pipe_freeze),
        .fwd_a_sel(d1_fwd_a), .fwd_b_sel(d1_fwd_b),
        .stall_cnt(d1_stall_cnt), .flush_cnt(d1_flush_cnt), .freeze_cnt(d1_freeze_cnt));

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_USE_STALLS(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .ex_branch_taken(br), .mem_busy(busy),
        .pc_hold(d2_pc_hold), .ifid_hold(d2_ifid_hold), .ifid_flush(d2_ifid_flush),
        .idex_bubble(d2_idex_bubble), .pipe_freeze(d2_pipe_freeze),
        .fwd_a_sel(d2_fwd_a), .fwd_b_sel(d2_fwd_b),
        .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt), .freeze_cnt(d2_freeze_cnt));

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .ex_branch_taken(br), .mem_busy(busy),
        .pc_hold(d3_pc_hold), .ifid_hold(d3_ifid_hold), .ifid_flush(d3_ifid_flush),
        .idex_bubble(d3_idex_bubble), .pipe_freeze(d3_pipe_freeze),
        .fwd_a_sel(d3_fwd_a), .fwd_b_sel(d3_fwd_b),
        .stall_cnt(d3_stall_cnt), .flush_cnt(d3_flush_cnt), .freeze_cnt(d3_freeze_cnt));

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urs, input logic urt,
                          input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; br = 1'b0; busy = 1'b0; nop();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; busy = 1'b1; br = 1'b1;
        set_id(1'b1, 5'd2, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        vec++;
        if ({d1_pc_hold, d1_ifid_hold, d1_ifid_flush, d1_idex_bubble, d1_pipe_freeze} !== 5'b00000) begin
            err++; $display("FAIL reset_ctrl: got %b want 00000",
                {d1_pc_hold, d1_ifid_hold, d1_ifid_flush, d1_idex_bubble, d1_pipe_freeze});
        end
        vec++;
        if ({d1_fwd_a, d1_fwd_b} !== 4'b0000) begin
            err++; $display("FAIL reset_fwd: got %b want 0000", {d1_fwd_a, d1_fwd_b});
        end
        cyc();
        @(negedge clk);
        vec++;
        if ({d1_stall_cnt, d1_flush_cnt, d1_freeze_cnt} !== 48'd0) begin
            err++; $display("FAIL reset_cnt: got %0h want 0", {d1_stall_cnt, d1_flush_cnt, d1_freeze_cnt});
        end
        rst = 1'b0; busy = 1'b0; br = 1'b0; nop();
    endtask

    task automatic test_forward();
        // add r3 ; sub r4,r3,r1 -> EX/MEM forward on A
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0); cyc();
        set_id(1'b1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0); cyc();
        nop();
        @(negedge clk);
        vec++;
        if (d1_fwd_a !== 2'b10) begin err++; $display("FAIL fwd_exmem_a: got %b want 10", d1_fwd_a); end
        vec++;
        if (d1_fwd_b !== 2'b00) begin err++; $display("FAIL fwd_exmem_b: got %b want 00", d1_fwd_b); end
        // add r3 ; or r6 ; sub r4,r3,r1 -> MEM/WB forward on A
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0); cyc();
        set_id(1'b1, 5'd7, 5'd8, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0); cyc();
        set_id(1'b1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0); cyc();
        nop();
        @(negedge clk);
        vec++;
        if (d1_fwd_a !== 2'b01) begin err++; $display("FAIL fwd_memwb_a: got %b want 01", d1_fwd_a); end
        // add r0 ; sub r4,r0,r1 -> never forward r0
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0); cyc();
        set_id(1'b1, 5'd0, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0); cyc();
        nop();
        @(negedge clk);
        vec++;
        if (d1_fwd_a !== 2'b00) begin err++; $display("FAIL fwd_r0: got %b want 00", d1_fwd_a); end
        // add r3 ; or r3 ; sub r4,r3,r3 -> EX/MEM wins on both operands
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0); cyc();
        set_id(1'b1, 5'd7, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0); cyc();
        set_id(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0); cyc();
        nop();
        @(negedge clk);
        vec++;
        if ({d1_fwd_a, d1_fwd_b} !== 4'b1010) begin
            err++; $display("FAIL fwd_priority: got %b want 1010", {d1_fwd_a, d1_fwd_b});
        end
    endtask

    task automatic test_load_use();
        // lw r2 ; add r5,r2,r2
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1); cyc();
        set_id(1'b1, 5'd2, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        vec++;
        if ({d1_pc_hold, d1_ifid_hold, d1_idex_bubble, d1_ifid_flush} !== 4'b1110) begin
            err++; $display("FAIL lu1_stall: got %b want 1110",
                {d1_pc_hold, d1_ifid_hold, d1_idex_bubble, d1_ifid_flush});
        end
        vec++;
        if (d2_idex_bubble !== 1'b1) begin err++; $display("FAIL lu2_stall1: got %b want 1", d2_idex_bubble); end
        cyc();
        @(negedge clk);
        vec++;
        if ({d1_pc_hold, d1_idex_bubble} !== 2'b00) begin
            err++; $display("FAIL lu1_release: got %b want 00", {d1_pc_hold, d1_idex_bubble});
        end
        vec++;
        if ({d2_pc_hold, d2_idex_bubble} !== 2'b11) begin
            err++; $display("FAIL lu2_stall2: got %b want 11", {d2_pc_hold, d2_idex_bubble});
        end
        cyc();
        nop();
        @(negedge clk);
        vec++;
        if ({d1_fwd_a, d1_fwd_b} !== 4'b0101) begin
            err++; $display("FAIL lu1_fwd: got %b want 0101", {d1_fwd_a, d1_fwd_b});
        end
        vec++;
        if (d1_stall_cnt !== 16'd1) begin err++; $display("FAIL lu1_cnt: got %0d want 1", d1_stall_cnt); end
        vec++;
        if (d2_stall_cnt !== 16'd2) begin err++; $display("FAIL lu2_cnt: got %0d want 2", d2_stall_cnt); end
        vec++;
        if (d2_pc_hold !== 1'b0) begin err++; $display("FAIL lu2_release: got %b want 0", d2_pc_hold); end
        // lw r2 ; or r6 ; add r5,r2,r2 -> one bubble with LOAD_USE_STALLS=2
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1); cyc();
        set_id(1'b1, 5'd7, 5'd8, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0); cyc();
        set_id(1'b1, 5'd2, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        vec++;
        if (d2_idex_bubble !== 1'b1) begin err++; $display("FAIL lu2_gap_stall: got %b want 1", d2_idex_bubble); end
        cyc();
        @(negedge clk);
        vec++;
        if (d2_idex_bubble !== 1'b0) begin err++; $display("FAIL lu2_gap_release: got %b want 0", d2_idex_bubble); end
        cyc();
        nop();
        @(negedge clk);
        vec++;
        if (d2_stall_cnt !== 16'd1) begin err++; $display("FAIL lu2_gap_cnt: got %0d want 1", d2_stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1); cyc();
        set_id(1'b1, 5'd2, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        br = 1'b1;
        @(negedge clk);
        vec++;
        if ({d1_ifid_flush, d1_idex_bubble, d1_pc_hold, d1_ifid_hold} !== 4'b1100) begin
            err++; $display("FAIL flush_ctrl: got %b want 1100",
                {d1_ifid_flush, d1_idex_bubble, d1_pc_hold, d1_ifid_hold});
        end
        cyc();
        br = 1'b0; nop();
        @(negedge clk);
        vec++;
        if (d1_flush_cnt !== 16'd1) begin err++; $display("FAIL flush_cnt: got %0d want 1", d1_flush_cnt); end
        vec++;
        if (d1_stall_cnt !== 16'd0) begin err++; $display("FAIL flush_stall_cnt: got %0d want 0", d1_stall_cnt); end
    endtask

    task automatic test_freeze();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0); cyc();   // add r3
        set_id(1'b1, 5'd3, 5'd2, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1); cyc();   // lw r2,0(r3)
        set_id(1'b1, 5'd2, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);          // add r5,r2,r2
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++;
            if ({d1_pipe_freeze, d1_pc_hold, d1_ifid_hold, d1_idex_bubble} !== 4'b1110) begin
                err++; $display("FAIL freeze_ctrl[%0d]: got %b want 1110", i,
                    {d1_pipe_freeze, d1_pc_hold, d1_ifid_hold, d1_idex_bubble});
            end
            vec++;
            if ({d1_fwd_a, d1_fwd_b} !== 4'b1000) begin
                err++; $display("FAIL freeze_fwd[%0d]: got %b want 1000", i, {d1_fwd_a, d1_fwd_b});
            end
            cyc();
        end
        busy = 1'b0;
        @(negedge clk);
        vec++;
        if ({d1_pipe_freeze, d1_pc_hold, d1_idex_bubble} !== 3'b011) begin
            err++; $display("FAIL freeze_then_stall: got %b want 011",
                {d1_pipe_freeze, d1_pc_hold, d1_idex_bubble});
        end
        vec++;
        if ({d1_fwd_a, d1_fwd_b} !== 4'b1000) begin
            err++; $display("FAIL freeze_fwd_after: got %b want 1000", {d1_fwd_a, d1_fwd_b});
        end
        vec++;
        if (d1_freeze_cnt !== 16'd3) begin err++; $display("FAIL freeze_cnt: got %0d want 3", d1_freeze_cnt); end
        cyc();
        @(negedge clk);
        vec++;
        if ({d1_pc_hold, d1_stall_cnt} !== {1'b0, 16'd1}) begin
            err++; $display("FAIL freeze_stall_done: got %b/%0d want 0/1", d1_pc_hold, d1_stall_cnt);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1); cyc();
        set_id(1'b1, 5'd2, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        busy = 1'b1;
        @(negedge clk);
        vec++;
        if (d1_pipe_freeze !== 1'b1) begin err++; $display("FAIL abort_pre: got %b want 1", d1_pipe_freeze); end
        cyc();
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if ({d1_pipe_freeze, d1_pc_hold, d1_ifid_hold} !== 3'b000) begin
            err++; $display("FAIL abort_in_rst: got %b want 000", {d1_pipe_freeze, d1_pc_hold, d1_ifid_hold});
        end
        cyc();
        rst = 1'b0; busy = 1'b0;
        @(negedge clk);
        vec++;
        if ({d1_pc_hold, d1_idex_bubble, d1_freeze_cnt} !== {2'b00, 16'd0}) begin
            err++; $display("FAIL abort_run: got %b/%0d want 00/0", {d1_pc_hold, d1_idex_bubble}, d1_freeze_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        br = 1'b1;
        repeat (20) cyc();
        @(negedge clk);
        vec++;
        if (d3_flush_cnt !== 4'd15) begin err++; $display("FAIL sat_flush4: got %0d want 15", d3_flush_cnt); end
        vec++;
        if (d1_flush_cnt !== 16'd20) begin err++; $display("FAIL flush16: got %0d want 20", d1_flush_cnt); end
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if ({d3_ifid_flush, d3_idex_bubble, d3_pc_hold, d3_pipe_freeze} !== 4'b0000) begin
            err++; $display("FAIL sat_rst_out: got %b want 0000",
                {d3_ifid_flush, d3_idex_bubble, d3_pc_hold, d3_pipe_freeze});
        end
        cyc();
        rst = 1'b0; br = 1'b0;
        @(negedge clk);
        vec++;
        if ({d3_stall_cnt, d3_flush_cnt, d3_freeze_cnt} !== 12'd0) begin
            err++; $display("FAIL sat_rst_cnt: got %0h want 0", {d3_stall_cnt, d3_flush_cnt, d3_freeze_cnt});
        end
        vec++;
        if ({d3_ifid_flush, d3_idex_bubble, d3_pc_hold} !== 3'b000) begin
            err++; $display("FAIL sat_run: got %b want 000", {d3_ifid_flush, d3_idex_bubble, d3_pc_hold});
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_flush();
        test_freeze();
        test_reset_abort();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
